dbus_arbiter: RTL and testbench

- Shares the single data-bus port (dbus_req_t / dbus_resp_t) between two requesters: the load unit (speculative reads) and the commit-side store unit (in-order writes).
- Replaces the combinational mread/mwrite mux at core level.
- Each requester gets a per-requester valid/ok handshake.
- The block registers the granted request, keeps it stable on the bus until data_ok, and drops responses for squashed loads.

---
 rtl/memory_pkg.sv | 48 ++++
 rtl/dbus_arbiter.sv | 117 +++++++++++
 tb/tb_dbus_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared memory-side types for the load unit, the commit-side store unit and the
// data-bus arbiter.
//   dbus_req_t / dbus_resp_t : data-bus request and response bundles
//   lreq_t / sreq_t          : per-requester request bundles
//   dbus_arb_state_t         : arbiter FSM states
//   DEFAULT_STARVE_LIMIT     : default store grants allowed while a load waits
package memory_pkg;

   typedef logic [2:0] msize_t;

   localparam int unsigned DEFAULT_STARVE_LIMIT = 4;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } dbus_req_t;

   typedef struct packed {
      logic        addr_ok;
      logic        data_ok;
      logic [63:0] data;
   } dbus_resp_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
   } lreq_t;

   typedef struct packed {
      logic        valid;
      logic [63:0] addr;
      msize_t      size;
      logic [7:0]  strobe;
      logic [63:0] data;
   } sreq_t;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      STORE,
      DRAIN
   } dbus_arb_state_t;

endpackage

// File: rtl/dbus_arbiter.sv
// Data-bus arbiter between the speculative load unit and the in-order store unit.
// Stores win by default; a waiting load is forced through after STARVE_LIMIT
// consecutive store grants. The granted request is registered and held on the bus
// until data_ok. Responses of loads squashed by lflush are dropped.
// Ports:
//   clk, reset                 : clock, asynchronous active-low reset
//   lreq_* / lflush            : load request and squash
//   lresp_ok / lresp_data      : load completion pulse and data
//   sreq_*                     : store request
//   sresp_ok                   : store completion pulse
//   dreq / dresp               : data-bus request / response
//   busy                       : a bus transaction is outstanding
module dbus_arbiter
   import memory_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
   localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1)
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        lreq_valid,
   input  logic [63:0] lreq_addr,
   input  logic [2:0]  lreq_size,
   input  logic        lflush,
   output logic        lresp_ok,
   output logic [63:0] lresp_data,
   input  logic        sreq_valid,
   input  logic [63:0] sreq_addr,
   input  logic [2:0]  sreq_size,
   input  logic [7:0]  sreq_strobe,
   input  logic [63:0] sreq_data,
   output logic        sresp_ok,
   output dbus_req_t   dreq,
   input  dbus_resp_t  dresp,
   output logic        busy
);

   dbus_arb_state_t  state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   dbus_req_t        dreq_q, dreq_d;
   logic             load_elig;
   logic             load_forced;

   // addr_ok does not sequence anything; data_ok alone ends a transaction.
   logic unused_addr_ok;
   assign unused_addr_ok = dresp.addr_ok;

   assign load_elig   = lreq_valid & ~lflush;
   assign load_forced = load_elig & (cnt_q == CNT_W'(STARVE_LIMIT));

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      dreq_d  = dreq_q;
      unique case (state_q)
         IDLE: begin
            dreq_d = '0;
            cnt_d  = '0;
            if (sreq_valid && !load_forced) begin
               state_d       = STORE;
               dreq_d.valid  = 1'b1;
               dreq_d.addr   = sreq_addr;
               dreq_d.size   = sreq_size;
               dreq_d.strobe = sreq_strobe;
               dreq_d.data   = sreq_data;
               // Only stores granted over a waiting load count towards starvation.
               if (load_elig) begin
                  cnt_d = (cnt_q == CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
               end
            end else if (load_elig) begin
               state_d      = LOAD;
               dreq_d.valid = 1'b1;
               dreq_d.addr  = lreq_addr;
               dreq_d.size  = lreq_size;
            end
         end
         LOAD: begin
            if (dresp.data_ok) begin
               state_d = IDLE;
               dreq_d  = '0;
            end else if (lflush) begin
               // Keep the bus request alive but swallow its response.
               state_d = DRAIN;
            end
         end
         STORE, DRAIN: begin
            if (dresp.data_ok) begin
               state_d = IDLE;
               dreq_d  = '0;
            end
         end
         default: begin
            state_d = IDLE;
            dreq_d  = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         dreq_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         dreq_q  <= dreq_d;
      end
   end

   assign dreq       = dreq_q;
   assign busy       = (state_q != IDLE);
   assign lresp_ok   = (state_q == LOAD) & dresp.data_ok & ~lflush;
   assign lresp_data = dresp.data;
   assign sresp_ok   = (state_q == STORE) & dresp.data_ok;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Self-checking bench for dbus_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbitration rules.
module tb_dbus_arbiter;
   import memory_pkg::*;

   localparam int unsigned Limit = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        lreq_valid;
   logic [63:0] lreq_addr;
   logic [2:0]  lreq_size;
   logic        lflush;
   logic        lresp_ok;
   logic [63:0] lresp_data;
   logic        sreq_valid;
   logic [63:0] sreq_addr;
   logic [2:0]  sreq_size;
   logic [7:0]  sreq_strobe;
   logic [63:0] sreq_data;
   logic        sresp_ok;
   dbus_req_t   dreq;
   dbus_resp_t  dresp;
   logic        busy;

   int checks = 0;
   int errors = 0;

   dbus_arbiter #(.STARVE_LIMIT(Limit)) dut (
      .clk        (clk),
      .reset      (reset),
      .lreq_valid (lreq_valid),
      .lreq_addr  (lreq_addr),
      .lreq_size  (lreq_size),
      .lflush     (lflush),
      .lresp_ok   (lresp_ok),
      .lresp_data (lresp_data),
      .sreq_valid (sreq_valid),
      .sreq_addr  (sreq_addr),
      .sreq_size  (sreq_size),
      .sreq_strobe(sreq_strobe),
      .sreq_data  (sreq_data),
      .sresp_ok   (sresp_ok),
      .dreq       (dreq),
      .dresp      (dresp),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Inputs change on the falling edge; outputs are sampled 1 time unit later.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      lreq_valid  = 1'b0;
      lreq_addr   = '0;
      lreq_size   = '0;
      lflush      = 1'b0;
      sreq_valid  = 1'b0;
      sreq_addr   = '0;
      sreq_size   = '0;
      sreq_strobe = '0;
      sreq_data   = '0;
      dresp       = '0;
   endtask

   task automatic do_reset();
      clear_inputs();
      cyc();
      reset = 1'b0;
      cyc();
      cyc();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1'b0;
      #1;
      checks++;
      if (dreq !== '0 || busy !== 1'b0 || lresp_ok !== 1'b0 || sresp_ok !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: dreq=%h busy=%b lok=%b sok=%b, required all 0",
                  dreq, busy, lresp_ok, sresp_ok);
      end
      do_reset();
   endtask

   task automatic test_store_only();
      do_reset();
      cyc();
      sreq_valid = 1'b1; sreq_addr = 64'h8000_1000; sreq_size = 3'd3;
      sreq_strobe = 8'hFF; sreq_data = 64'hDEAD_BEEF;
      #1;
      checks++;
      if (dreq.valid !== 1'b0) begin
         errors++; $display("FAIL store_latency: dreq.valid=%b, required 0", dreq.valid);
      end
      cyc(); #1;
      checks++;
      if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_1000 || dreq.data !== 64'hDEAD_BEEF
          || dreq.size !== 3'd3) begin
         errors++;
         $display("FAIL store_grant: v=%b addr=%h data=%h size=%0d, required 1 80001000 deadbeef 3",
                  dreq.valid, dreq.addr, dreq.data, dreq.size);
      end
      for (int i = 1; i <= 3; i++) begin
         cyc();
         sreq_data = 64'h5555_0000 + 64'(i);  // must be ignored after the grant
         dresp.data_ok = (i == 3);
         #1;
         checks++;
         if (dreq.valid !== 1'b1 || dreq.strobe !== 8'hFF || dreq.data !== 64'hDEAD_BEEF
             || sresp_ok !== (i == 3) || lresp_ok !== 1'b0) begin
            errors++;
            $display("FAIL store_hold[%0d]: v=%b strb=%h data=%h sok=%b lok=%b", i,
                     dreq.valid, dreq.strobe, dreq.data, sresp_ok, lresp_ok);
         end
      end
      cyc();
      sreq_valid = 1'b0; dresp.data_ok = 1'b0;
      #1;
      checks++;
      if (dreq.valid !== 1'b0 || busy !== 1'b0 || sresp_ok !== 1'b0) begin
         errors++;
         $display("FAIL store_done: v=%b busy=%b sok=%b, required 0 0 0",
                  dreq.valid, busy, sresp_ok);
      end
   endtask

   task automatic test_load_only();
      do_reset();
      cyc();
      lreq_valid = 1'b1; lreq_addr = 64'h8000_2000; lreq_size = 3'd3;
      sreq_data = 64'hFFFF_FFFF; sreq_strobe = 8'hAA;
      #1;
      cyc(); #1;
      checks++;
      if (dreq.valid !== 1'b1 || dreq.addr !== 64'h8000_2000 || dreq.size !== 3'd3
          || dreq.strobe !== 8'h00 || dreq.data !== 64'h0) begin
         errors++;
         $display("FAIL load_grant: v=%b addr=%h size=%0d strb=%h data=%h",
                  dreq.valid, dreq.addr, dreq.size, dreq.strobe, dreq.data);
      end
      cyc();
      dresp.data = 64'h1234; dresp.data_ok = 1'b1;
      #1;
      checks++;
      if (lresp_ok !== 1'b1 || lresp_data !== 64'h1234 || sresp_ok !== 1'b0) begin
         errors++;
         $display("FAIL load_resp: lok=%b data=%h sok=%b, required 1 1234 0",
                  lresp_ok, lresp_data, sresp_ok);
      end
      cyc();
      lreq_valid = 1'b0; dresp.data_ok = 1'b0;
      #1;
      checks++;
      if (dreq.valid !== 1'b0 || busy !== 1'b0 || lresp_ok !== 1'b0) begin
         errors++;
         $display("FAIL load_done: v=%b busy=%b lok=%b, required 0 0 0",
                  dreq.valid, busy, lresp_ok);
      end
   endtask

   task automatic test_starvation();
      int stores;
      bit got_load;
      do_reset();
      for (int round = 0; round < 2; round++) begin
         cyc();
         sreq_valid = 1'b1; sreq_addr = 64'h100; sreq_strobe = 8'h0F;
         lreq_valid = 1'b1; lreq_addr = 64'h200; lflush = 1'b0;
         dresp.data_ok = dreq.valid;
         stores = 0;
         got_load = 1'b0;
         #1;
         for (int c = 0; c < 200 && !got_load; c++) begin
            cyc();
            dresp.data_ok = dreq.valid;  // bus answers immediately
            #1;
            if (sresp_ok === 1'b1) stores++;
            if (lresp_ok === 1'b1) got_load = 1'b1;
         end
         checks++;
         if (!got_load || stores != int'(Limit)) begin
            errors++;
            $display("FAIL starve_round%0d: load_done=%b stores_before=%0d, required 1 %0d",
                     round, got_load, stores, Limit);
         end
         checks++;
         if (dut.cnt_q != 0) begin
            errors++;
            $display("FAIL starve_cnt%0d: counter=%0d, required 0", round, dut.cnt_q);
         end
         cyc();
         lreq_valid = 1'b0; sreq_valid = 1'b0; dresp.data_ok = 1'b0;
         cyc();
      end
   endtask

   task automatic test_flush_mid_load();
      dbus_req_t held;
      do_reset();
      cyc();
      lreq_valid = 1'b1; lreq_addr = 64'h8000_3000; lreq_size = 3'd2;
      cyc(); #1;
      held = dreq;
      cyc();
      lflush = 1'b1;
      #1;
      checks++;
      if (lresp_ok !== 1'b0) begin
         errors++; $display("FAIL flush_lok0: lok=%b, required 0", lresp_ok);
      end
      cyc();
      lflush = 1'b0; lreq_valid = 1'b0;
      #1;
      checks++;
      if (dut.state_q !== DRAIN || dreq !== held || held.valid !== 1'b1) begin
         errors++;
         $display("FAIL flush_drain: state=%0d dreq=%h, required %0d %h",
                  dut.state_q, dreq, DRAIN, held);
      end
      cyc();
      dresp.data_ok = 1'b1; dresp.data = 64'hBAD;
      #1;
      checks++;
      if (lresp_ok !== 1'b0 || sresp_ok !== 1'b0 || dreq !== held) begin
         errors++;
         $display("FAIL flush_dataok: lok=%b sok=%b dreq=%h", lresp_ok, sresp_ok, dreq);
      end
      cyc();
      dresp.data_ok = 1'b0;
      #1;
      checks++;
      if (dut.state_q !== IDLE || busy !== 1'b0 || dreq.valid !== 1'b0) begin
         errors++;
         $display("FAIL flush_idle: state=%0d busy=%b v=%b, required IDLE 0 0",
                  dut.state_q, busy, dreq.valid);
      end
   endtask

   task automatic test_flush_idle();
      do_reset();
      cyc();
      lreq_valid = 1'b1; lflush = 1'b1; sreq_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         cyc(); #1;
         checks++;
         if (dreq.valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL flush_idle_nogrant[%0d]: v=%b busy=%b, required 0 0",
                     i, dreq.valid, busy);
         end
      end
      clear_inputs();
   endtask

   task automatic test_async_reset();
      do_reset();
      cyc();
      sreq_valid = 1'b1; sreq_addr = 64'h40; sreq_strobe = 8'hFF;
      cyc(); #1;
      checks++;
      if (dreq.valid !== 1'b1 || dut.state_q !== STORE) begin
         errors++;
         $display("FAIL areset_pre: v=%b state=%0d, required 1 STORE", dreq.valid, dut.state_q);
      end
      #2;
      reset = 1'b0;
      dresp.data_ok = 1'b1;
      #1;
      checks++;
      if (dreq.valid !== 1'b0 || dut.state_q !== IDLE || sresp_ok !== 1'b0 || busy !== 1'b0)
      begin
         errors++;
         $display("FAIL areset_now: v=%b state=%0d sok=%b busy=%b, required 0 IDLE 0 0",
                  dreq.valid, dut.state_q, sresp_ok, busy);
      end
      cyc();
      clear_inputs();
      reset = 1'b1;
   endtask

   // Transaction-level model: the bus is either free or owned by one transaction
   // whose request was captured at its grant; stores granted over a waiting load
   // are tallied and the load wins once the tally reaches Limit.
   task automatic test_random();
      int        owner;     // 0 free, 1 load, 2 store, 3 squashed load
      int        tally;
      int        wait_left;
      dbus_req_t cap;
      dbus_req_t exp_req;
      bit        l_drop, s_drop, dok, exp_l, exp_s, le;
      do_reset();
      owner = 0; tally = 0; wait_left = 0; cap = '0; l_drop = 0; s_drop = 0;
      for (int c = 0; c < 3000; c++) begin
         cyc();
         if (l_drop) begin
            lreq_valid = 1'b0; l_drop = 0;
         end else if (!lreq_valid && $urandom_range(0, 2) == 0) begin
            lreq_valid = 1'b1; lreq_size = 3'($urandom_range(0, 3));
         end
         lreq_addr = {$urandom, $urandom};
         lflush = lreq_valid && ($urandom_range(0, 9) == 0);
         if (s_drop) begin
            sreq_valid = 1'b0; s_drop = 0;
         end else if (!sreq_valid && $urandom_range(0, 1) == 0) begin
            sreq_valid = 1'b1;
         end
         sreq_addr = {$urandom, $urandom}; sreq_size = 3'($urandom_range(0, 3));
         sreq_strobe = 8'($urandom); sreq_data = {$urandom, $urandom};
         dok = 0;
         if (owner != 0) begin
            if (wait_left == 0) dok = 1;
            else wait_left--;
         end
         dresp.data_ok = dok; dresp.addr_ok = 1'($urandom); dresp.data = {$urandom, $urandom};
         #1;
         exp_req = (owner != 0) ? cap : '0;
         exp_l = (owner == 1) && dok && !lflush;
         exp_s = (owner == 2) && dok;
         checks++;
         if (dreq !== exp_req || busy !== (owner != 0) || lresp_ok !== exp_l
             || sresp_ok !== exp_s || (exp_l && lresp_data !== dresp.data)) begin
            errors++;
            $display("FAIL rand[%0d]: dreq=%h busy=%b lok=%b sok=%b, required %h %b %b %b",
                     c, dreq, busy, lresp_ok, sresp_ok, exp_req, owner != 0, exp_l, exp_s);
         end
         if (exp_l || (lreq_valid && lflush)) l_drop = 1;
         if (exp_s) s_drop = 1;
         if (owner == 0) begin
            le = lreq_valid && !lflush;
            if (sreq_valid && !(le && tally >= int'(Limit))) begin
               owner = 2;
               tally = le ? tally + 1 : 0;
               cap = '0;
               cap.valid = 1'b1; cap.addr = sreq_addr; cap.size = sreq_size;
               cap.strobe = sreq_strobe; cap.data = sreq_data;
               wait_left = $urandom_range(0, 3);
            end else if (le) begin
               owner = 1; tally = 0;
               cap = '0;
               cap.valid = 1'b1; cap.addr = lreq_addr; cap.size = lreq_size;
               wait_left = $urandom_range(0, 3);
            end else begin
               tally = 0;
            end
         end else if (dok) begin
            owner = 0;
         end else if (owner == 1 && lflush) begin
            owner = 3;
         end
      end
      clear_inputs();
   endtask

   initial begin
      reset = 1'b1;
      clear_inputs();
      test_reset();
      test_store_only();
      test_load_only();
      test_starvation();
      test_flush_mid_load();
      test_flush_idle();
      test_async_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
